// File: rtl/mcyc_seq.sv
// -----------------------------------------------------------------------------
// mcyc_seq -- machine-cycle / T-state sequencer for the 8-bit CPU core.
//
// Walks each instruction through M1 (opcode fetch, T1..T4 or T1..T6) and up to
// four further machine cycles M2..M5 (three T-states each, read or write).
// It drives the datapath load/enable strobes and the external bus strobes and
// status. All outputs are decoded from registered state only. The one
// exception is the M1/T4 register write-back, which reads chk_i combinationally.
// chk_i only becomes valid at T4, so that strobe cannot be registered
// earlier. ready and chk_i never reach the bus strobes combinationally.
//
// Optional feature macro: READY_WAIT_EN
//   defined   : ready is sampled at the end of T2/TW and wait states (TW) are
//               inserted while it is low.
//   undefined : ready is ignored, T2 always proceeds to T3.
//
// Ports:
//   clk              core clock, rising edge
//   rst              asynchronous active-high reset
//   chk_i            instruction info: [0] go6, [2] halt, [3] dio,
//                    [7:4] cycgo, [11:8] cycrw, [12] ccc
//   cond             current opcode is conditional
//   ready            bus ready (low requests wait states)
//   ale, rd_, wr_    address latch enable, read/write strobes (active low)
//   iom              1 = I/O cycle, 0 = memory cycle
//   s1, s0           bus status: fetch 11, read 10, write 01, halt 00
//   enb_c, enb_d     load instruction register / temp register
//   enbpc            advance PC
//   enbrr, enbwr     register read / write enables
//   mcyc             current machine cycle 1..5
//   tstate           current T-state: 0 HALT, 1..6 T1..T6, 7 TW
// -----------------------------------------------------------------------------
module mcyc_seq #(
    parameter int INSTSIZE = 13,
    parameter int CYCBITS  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTSIZE-1:0] chk_i,
    input  logic                cond,
    input  logic                ready,
    output logic                ale,
    output logic                rd_,
    output logic                wr_,
    output logic                iom,
    output logic                s1,
    output logic                s0,
    output logic                enb_c,
    output logic                enb_d,
    output logic                enbpc,
    output logic                enbrr,
    output logic                enbwr,
    output logic [2:0]          mcyc,
    output logic [2:0]          tstate
);

    localparam logic [2:0] T_HALT = 3'd0;
    localparam logic [2:0] T_1    = 3'd1;
    localparam logic [2:0] T_2    = 3'd2;
    localparam logic [2:0] T_3    = 3'd3;
    localparam logic [2:0] T_4    = 3'd4;
    localparam logic [2:0] T_5    = 3'd5;
    localparam logic [2:0] T_6    = 3'd6;
    localparam logic [2:0] T_W    = 3'd7;

    localparam logic [2:0] M_1 = 3'd1;
    localparam logic [2:0] M_2 = 3'd2;
    localparam logic [2:0] M_3 = 3'd3;
    localparam logic [2:0] M_4 = 3'd4;

    // instruction-info fields
    logic               go6_s;
    logic               halt_s;
    logic               dio_s;
    logic               ccc_s;
    logic [CYCBITS-1:0] cycgo_s;
    logic [CYCBITS-1:0] cycrw_s;

    assign go6_s   = chk_i[0];
    assign halt_s  = chk_i[2];
    assign dio_s   = chk_i[3];
    assign ccc_s   = chk_i[12];
    assign cycgo_s = chk_i[4 +: CYCBITS];
    assign cycrw_s = chk_i[8 +: CYCBITS];

    logic unused_s;
    assign unused_s = ^{chk_i[1], ready};

    // state registers
    logic [2:0]         mcyc_r;
    logic [2:0]         tstate_r;
    logic               run_r;    // low until the first clock after reset
    logic               wb_r;     // write-back pending for the coming M1/T1
    logic               wtype_r;  // current machine cycle is a write
    logic               io_r;     // current machine cycle is an I/O cycle
    logic [CYCBITS-1:0] mask_r;   // effective extra-cycle mask of this instruction

    logic [2:0]         nxt_m_s;
    logic [2:0]         nxt_t_s;
    logic               nxt_wb_s;
    logic               nxt_wtype_s;
    logic               nxt_io_s;
    logic [CYCBITS-1:0] nxt_mask_s;

    logic               wait_s;
    logic               more_s;
    logic               nrw_s;
    logic               end_m1_s;
    logic [CYCBITS-1:0] eff_mask_s;

`ifdef READY_WAIT_EN
    assign wait_s = ~ready;
`else
    assign wait_s = 1'b0;
`endif

    // A failed condition skips Rccc's pops entirely; other conditionals keep only M2.
    assign eff_mask_s = (cond & ~ccc_s)
                      ? ((go6_s && (cycgo_s == CYCBITS'(2'b11)))
                         ? {CYCBITS{1'b0}}
                         : {{(CYCBITS-1){1'b0}}, cycgo_s[0]})
                      : cycgo_s;

    // look-ahead: does another machine cycle follow the current Mn, and its type
    always_comb begin
        more_s = 1'b0;
        nrw_s  = 1'b0;
        case (mcyc_r)
            M_2: begin
                more_s = mask_r[1];
                nrw_s  = cycrw_s[1];
            end
            M_3: begin
                more_s = mask_r[2];
                nrw_s  = cycrw_s[2];
            end
            M_4: begin
                more_s = mask_r[3];
                nrw_s  = cycrw_s[3];
            end
            default: begin
                more_s = 1'b0;
                nrw_s  = 1'b0;
            end
        endcase
    end

    // next-state logic for the machine-cycle / T-state walk
    always_comb begin
        nxt_m_s     = mcyc_r;
        nxt_t_s     = tstate_r;
        nxt_wb_s    = wb_r;
        nxt_wtype_s = wtype_r;
        nxt_io_s    = io_r;
        nxt_mask_s  = mask_r;
        end_m1_s    = 1'b0;
        if (!run_r) begin
            nxt_m_s = M_1;
            nxt_t_s = T_1;
        end else begin
            case (tstate_r)
                T_1: begin
                    nxt_t_s  = T_2;
                    nxt_wb_s = 1'b0;
                end
                T_2, T_W: begin
                    nxt_t_s = wait_s ? T_W : T_3;
                end
                T_3: begin
                    if (mcyc_r == M_1) begin
                        nxt_t_s = T_4;
                    end else if (more_s) begin
                        nxt_m_s     = mcyc_r + 3'd1;
                        nxt_t_s     = T_1;
                        nxt_wtype_s = nrw_s;
                        nxt_io_s    = (mcyc_r == M_2) & dio_s;
                    end else begin
                        // last Mn: a read result is written back during M1/T1
                        nxt_m_s     = M_1;
                        nxt_t_s     = T_1;
                        nxt_wb_s    = ~wtype_r;
                        nxt_wtype_s = 1'b0;
                        nxt_io_s    = 1'b0;
                    end
                end
                T_4: begin
                    if (halt_s) begin
                        nxt_t_s = T_HALT;
                    end else if (go6_s) begin
                        nxt_t_s = T_5;
                    end else begin
                        end_m1_s = 1'b1;
                    end
                end
                T_5: begin
                    nxt_t_s = T_6;
                end
                T_6: begin
                    end_m1_s = 1'b1;
                end
                T_HALT: begin
                    nxt_t_s = T_HALT;
                end
                default: begin
                    nxt_m_s = M_1;
                    nxt_t_s = T_1;
                end
            endcase
            if (end_m1_s) begin
                nxt_mask_s = eff_mask_s;
                nxt_t_s    = T_1;
                nxt_io_s   = 1'b0;
                if (eff_mask_s[0]) begin
                    nxt_m_s     = M_2;
                    nxt_wtype_s = cycrw_s[0];
                end else begin
                    nxt_m_s     = M_1;
                    nxt_wtype_s = 1'b0;
                end
            end else begin
                nxt_mask_s = mask_r;
            end
        end
    end

    // state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcyc_r   <= M_1;
            tstate_r <= T_1;
            run_r    <= 1'b0;
            wb_r     <= 1'b0;
            wtype_r  <= 1'b0;
            io_r     <= 1'b0;
            mask_r   <= {CYCBITS{1'b0}};
        end else begin
            mcyc_r   <= nxt_m_s;
            tstate_r <= nxt_t_s;
            run_r    <= 1'b1;
            wb_r     <= nxt_wb_s;
            wtype_r  <= nxt_wtype_s;
            io_r     <= nxt_io_s;
            mask_r   <= nxt_mask_s;
        end
    end

    logic is_m1_s;
    logic strobe_s;
    logic t4_wb_s;
    logic t1_wb_s;

    assign is_m1_s  = (mcyc_r == M_1);
    assign strobe_s = (tstate_r == T_2) | (tstate_r == T_W) | (tstate_r == T_3);
    assign t4_wb_s  = is_m1_s & (tstate_r == T_4) & ~halt_s & ~go6_s
                    & (cycgo_s == {CYCBITS{1'b0}});
    assign t1_wb_s  = is_m1_s & (tstate_r == T_1) & wb_r;

    // output decode from the registered state
    always_comb begin
        ale    = run_r & (tstate_r == T_1);
        rd_    = ~(strobe_s & ~wtype_r);
        wr_    = ~(strobe_s & wtype_r);
        iom    = io_r;
        enb_c  = is_m1_s & (tstate_r == T_3);
        enb_d  = ~is_m1_s & ~wtype_r & (tstate_r == T_3);
        enbpc  = ~wtype_r & (tstate_r == T_2);
        enbrr  = t1_wb_s | t4_wb_s
               | (~is_m1_s & wtype_r & ((tstate_r == T_2) | (tstate_r == T_3)));
        enbwr  = t1_wb_s | t4_wb_s;
        mcyc   = mcyc_r;
        tstate = tstate_r;
        if (tstate_r == T_HALT) begin
            s1 = 1'b0;
            s0 = 1'b0;
        end else if (is_m1_s) begin
            s1 = 1'b1;
            s0 = 1'b1;
        end else begin
            s1 = ~wtype_r;
            s0 = wtype_r;
        end
    end

endmodule
